// File: rtl/ibex_rf_wipe_pkg.sv
// Shared types and helpers for the register-file wipe controller.
package ibex_rf_wipe_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WIPE = 2'd1,
      DONE = 2'd2
   } rf_wipe_state_e;

   function automatic int unsigned rf_addr_width(input bit rv32e);
      return rv32e ? 32'd4 : 32'd5;
   endfunction

endpackage

// File: rtl/ibex_rf_wipe_ctrl.sv
// Register-file wipe sequencer: zeroes x1..xN-1 and muxes the RF write
// port between the core writeback and the wipe counter.
module ibex_rf_wipe_ctrl
   import ibex_rf_wipe_pkg::*;
#(
   parameter bit                   RV32E       = 1'b0,
   parameter int unsigned          DataWidth   = 32,
   parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wipe_req_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   input  logic [4:0]           core_waddr_i,
   input  logic [DataWidth-1:0] core_wdata_i,
   input  logic                 core_we_i,
   output logic                 core_stall_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 rf_we_o
);

   localparam int unsigned   ADDR_WIDTH = rf_addr_width(RV32E);
   localparam int unsigned   NUM_WORDS  = 32'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

   rf_wipe_state_e          r_state;
   rf_wipe_state_e          w_state;
   rf_wipe_state_e          w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_cnt;
   logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
   logic                    r_err;
   logic                    r_req_q;
   logic                    w_req_edge;
   logic [4:0]              w_waddr;

   // A reset cycle already behaves as IDLE so no wipe write slips out.
   assign w_state    = rst_i ? IDLE : r_state;
   // The held level that launched a wipe is not an overlapping request.
   assign w_req_edge = wipe_req_i & ~r_req_q;
   assign err_o      = r_err;
   assign rf_waddr_o = RV32E ? {1'b0, w_waddr[3:0]} : w_waddr;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_req_q <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_req_q <= wipe_req_i;
         if (busy_o && w_req_edge) begin
            r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      core_stall_o = 1'b0;
      rf_we_o      = core_we_i;
      w_waddr      = core_waddr_i;
      rf_wdata_o   = core_wdata_i;
      unique case (w_state)
         IDLE: begin
            if (wipe_req_i) begin
               w_state_nxt = WIPE;
               w_cnt_nxt   = ADDR_WIDTH'(1);
            end
         end
         WIPE: begin
            busy_o       = 1'b1;
            core_stall_o = 1'b1;
            rf_we_o      = 1'b1;
            w_waddr      = 5'(r_cnt);
            rf_wdata_o   = WordZeroVal;
            if (r_cnt == LAST_ADDR) begin
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         DONE: begin
            busy_o       = 1'b1;
            done_o       = 1'b1;
            core_stall_o = 1'b1;
            rf_we_o      = 1'b0;
            w_state_nxt  = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ibex_rf_wipe_ctrl.sv
// Bench for ibex_rf_wipe_ctrl: RV32I and RV32E instances share stimulus
// and are checked every cycle against a wipe-schedule model.
module tb_ibex_rf_wipe_ctrl;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic          cwe;
   logic [4:0]    cwa;
   logic [DW-1:0] cwd;

   logic          busy  [2];
   logic          done  [2];
   logic          err   [2];
   logic          stall [2];
   logic          we    [2];
   logic [4:0]    wa    [2];
   logic [DW-1:0] wd    [2];

   logic [DW-1:0] dmem [2][32];
   logic [DW-1:0] emem [2][32];

   int  start [2];
   bit  merr  [2];
   bit  prev_req;
   int  cyc;
   int  checks;
   int  failures;

   always #5 clk = ~clk;

   ibex_rf_wipe_ctrl #(
      .RV32E      (1'b0),
      .DataWidth  (DW),
      .WordZeroVal('0)
   ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .wipe_req_i  (req),
      .busy_o      (busy[0]),
      .done_o      (done[0]),
      .err_o       (err[0]),
      .core_waddr_i(cwa),
      .core_wdata_i(cwd),
      .core_we_i   (cwe),
      .core_stall_o(stall[0]),
      .rf_waddr_o  (wa[0]),
      .rf_wdata_o  (wd[0]),
      .rf_we_o     (we[0])
   );

   ibex_rf_wipe_ctrl #(
      .RV32E      (1'b1),
      .DataWidth  (DW),
      .WordZeroVal('0)
   ) u_dut_e (
      .clk_i       (clk),
      .rst_i       (rst),
      .wipe_req_i  (req),
      .busy_o      (busy[1]),
      .done_o      (done[1]),
      .err_o       (err[1]),
      .core_waddr_i(cwa),
      .core_wdata_i(cwd),
      .core_we_i   (cwe),
      .core_stall_o(stall[1]),
      .rf_waddr_o  (wa[1]),
      .rf_wdata_o  (wd[1]),
      .rf_we_o     (we[1])
   );

   always @(posedge clk) begin
      if (we[0] === 1'b1) dmem[0][wa[0]] <= wd[0];
      if (we[1] === 1'b1) dmem[1][wa[1]] <= wd[1];
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h",
                tag, cyc, obs, exp);
      end
   endtask

   // One clock of stimulus; outputs checked at the falling edge.
   task automatic step(input bit r, input bit q, input bit w,
                       input logic [4:0] a, input logic [DW-1:0] d);
      int n;
      int p;
      bit act;
      bit eb, es, ed, ewe;
      logic [4:0]    ea;
      logic [DW-1:0] edat;
      rst = r; req = q; cwe = w; cwa = a; cwd = d;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n    = (k == 1) ? 16 : 32;
         act  = !r && start[k] >= 0;
         p    = cyc - start[k];
         eb   = 1'b0; es = 1'b0; ed = 1'b0;
         ewe  = w;
         ea   = (k == 1) ? {1'b0, a[3:0]} : a;
         edat = d;
         if (act) begin
            eb = 1'b1;
            es = 1'b1;
            if (p < n) begin
               ewe  = 1'b1;
               ea   = 5'(p);
               edat = '0;
            end else begin
               ed  = 1'b1;
               ewe = 1'b0;
            end
         end
         chk($sformatf("busy%0d", k),  32'(busy[k]),  32'(eb));
         chk($sformatf("stall%0d", k), 32'(stall[k]), 32'(es));
         chk($sformatf("done%0d", k),  32'(done[k]),  32'(ed));
         chk($sformatf("we%0d", k),    32'(we[k]),    32'(ewe));
         chk($sformatf("err%0d", k),   32'(err[k]),   32'(merr[k]));
         chk($sformatf("waddr4_%0d", k), 32'(wa[k][4]),
             (k == 1) ? 32'd0 : 32'(ea[4]));
         if (ewe) begin
            chk($sformatf("waddr%0d", k), 32'(wa[k]), 32'(ea));
            chk($sformatf("wdata%0d", k), wd[k], edat);
            emem[k][ea] = edat;
         end
         if (r) begin
            start[k] = -1;
            merr[k]  = 1'b0;
         end else if (act) begin
            if (q && !prev_req) merr[k] = 1'b1;
            if (p == n) start[k] = -1;
         end else if (q) begin
            start[k] = cyc;
         end
      end
      prev_req = r ? 1'b0 : q;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         step(1'b0, 1'b0, 1'b0, 5'($urandom), $urandom);
      end
   endtask

   task automatic preload();
      for (int i = 1; i < 32; i++) begin
         step(1'b0, 1'b0, 1'b1, i[4:0], 32'hA5A5A5A5);
      end
   endtask

   task automatic mem_chk(input string tag);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 32; i++) begin
            if (!$isunknown(emem[k][i])) begin
               chk($sformatf("%s_mem%0d_x%0d", tag, k, i),
                   dmem[k][i], emem[k][i]);
            end
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      prev_req = 1'b0;
      for (int k = 0; k < 2; k++) begin
         start[k] = -1;
         merr[k]  = 1'b0;
         for (int i = 0; i < 32; i++) emem[k][i] = 'x;
      end
      rst = 1'b1; req = 1'b0; cwe = 1'b0; cwa = '0; cwd = '0;
      @(posedge clk);
      #1;
      cyc++;
      step(1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
      step(1'b1, 1'b1, 1'b1, 5'd4, 32'h55);
      idle(2);

      // basic wipe
      preload();
      step(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      idle(34);
      mem_chk("basic");

      // collision with core writeback
      preload();
      step(1'b0, 1'b1, 1'b1, 5'd5, 32'h1234);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, 5'd7, 32'hBEEF);
      mem_chk("collide");

      // overlapping request in cycle 10
      preload();
      step(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      idle(9);
      step(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      idle(30);
      mem_chk("overlap");

      // reset in cycle 8 of a wipe
      preload();
      step(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      idle(7);
      step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      idle(40);
      mem_chk("rstmid");

      // back-to-back with a held request
      preload();
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
      idle(40);
      mem_chk("b2b");

      // random traffic
      for (int i = 0; i < 500; i++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
              1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      end
      idle(40);
      mem_chk("rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
